// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and engine-side signals of the I2C transaction arbiter.
// The master modport is the arbiter itself; slave is the requesters plus the engine.
interface i2c_txn_arbiter_if #(
    parameter int unsigned NREQ = 2
) ();
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_rw;
    logic [6*NREQ-1:0] req_len;
    logic [8*NREQ-1:0] wr_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   wr_pop;
    logic [7:0]        rd_data;
    logic [NREQ-1:0]   rd_valid;
    logic [NREQ-1:0]   done;
    logic              nack;
    logic [2:0]        eng_cmd;
    logic [7:0]        eng_wdata;
    logic              eng_valid;
    logic              eng_ready;
    logic              eng_done;
    logic [7:0]        eng_rdata;
    logic              eng_nack;

    modport master (
        input  req, req_addr, req_rw, req_len, wr_data,
        input  eng_ready, eng_done, eng_rdata, eng_nack,
        output grant, wr_pop, rd_data, rd_valid, done, nack,
        output eng_cmd, eng_wdata, eng_valid
    );

    modport slave (
        output req, req_addr, req_rw, req_len, wr_data,
        output eng_ready, eng_done, eng_rdata, eng_nack,
        input  grant, wr_pop, rd_data, rd_valid, done, nack,
        input  eng_cmd, eng_wdata, eng_valid
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C engine between NREQ requesters,
// sequencing each grant as START, address, 0..32 data bytes, STOP.
module i2c_txn_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    i2c_txn_arbiter_if.master  bus
);
    localparam int unsigned IdxW = 2;

    localparam logic [2:0] CmdNone     = 3'd0;
    localparam logic [2:0] CmdStart    = 3'd1;
    localparam logic [2:0] CmdWrite    = 3'd2;
    localparam logic [2:0] CmdReadAck  = 3'd3;
    localparam logic [2:0] CmdReadNack = 3'd4;
    localparam logic [2:0] CmdStop     = 3'd5;

    typedef enum logic [2:0] {StIdle, StStart, StAddr, StWdata, StRdata, StStop, StDone} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   grant_q, rd_valid_q, done_q;
    logic [IdxW-1:0]   last_q, own_q;
    logic [6:0]        addr_q;
    logic              rw_q;
    logic [5:0]        len_q, cnt_q;
    logic              wait_q;       // command accepted, waiting for its eng_done
    logic              nack_q;
    logic [7:0]        rd_data_q, eng_wdata_q;
    logic [2:0]        eng_cmd_q;
    logic              eng_valid_q;

    logic [3:0]        req_ext, rw_ext;
    logic [IdxW-1:0]   cand, win_idx;
    logic              win_found;
    logic [5:0]        raw_len, win_len, cnt_inc;
    logic [7:0]        own_wdata;
    logic              accept;

    assign req_ext   = 4'(bus.req);
    assign rw_ext    = 4'(bus.req_rw);
    assign raw_len   = bus.req_len[6*win_idx +: 6];
    assign win_len   = (raw_len > 6'd32) ? 6'd32 : raw_len;
    assign own_wdata = bus.wr_data[8*own_q +: 8];
    assign accept    = eng_valid_q & bus.eng_ready;
    assign cnt_inc   = cnt_q + 6'd1;

    // Round-robin search starting one past the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IdxW'((32'(last_q) + off) % NREQ);
            if (!win_found && req_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The write byte is consumed in the cycle the engine accepts its WRITE.
    always_comb begin
        bus.wr_pop = '0;
        if (state_q == StWdata && accept) begin
            bus.wr_pop = grant_q;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;
    assign bus.nack      = nack_q;
    assign bus.eng_cmd   = eng_cmd_q;
    assign bus.eng_wdata = eng_wdata_q;
    assign bus.eng_valid = eng_valid_q;

    // Transaction sequencer: one command outstanding, next one issued on the previous eng_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rd_valid_q  <= '0;
            done_q      <= '0;
            last_q      <= IdxW'(NREQ - 1);
            own_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= 1'b0;
            nack_q      <= 1'b0;
            rd_data_q   <= '0;
            eng_wdata_q <= '0;
            eng_cmd_q   <= CmdNone;
            eng_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            done_q     <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q     <= NREQ'(1) << win_idx;
                        own_q       <= win_idx;
                        addr_q      <= bus.req_addr[7*win_idx +: 7];
                        rw_q        <= rw_ext[win_idx];
                        len_q       <= win_len;
                        cnt_q       <= '0;
                        nack_q      <= 1'b0;
                        wait_q      <= 1'b0;
                        eng_valid_q <= 1'b1;
                        eng_cmd_q   <= CmdStart;
                        state_q     <= StStart;
                    end
                end
                StDone: begin
                    last_q  <= own_q;
                    grant_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    if (eng_valid_q) begin
                        // An eng_done in the accept cycle is deliberately not looked at.
                        if (bus.eng_ready) begin
                            eng_valid_q <= 1'b0;
                            wait_q      <= 1'b1;
                        end
                    end else if (wait_q && bus.eng_done) begin
                        wait_q <= 1'b0;
                        case (state_q)
                            StStart: begin
                                state_q     <= StAddr;
                                eng_valid_q <= 1'b1;
                                eng_cmd_q   <= CmdWrite;
                                eng_wdata_q <= {addr_q, rw_q};
                            end
                            StAddr: begin
                                eng_valid_q <= 1'b1;
                                if (bus.eng_nack || len_q == 6'd0) begin
                                    nack_q    <= bus.eng_nack;
                                    state_q   <= StStop;
                                    eng_cmd_q <= CmdStop;
                                end else if (rw_q) begin
                                    state_q   <= StRdata;
                                    eng_cmd_q <= (len_q == 6'd1) ? CmdReadNack : CmdReadAck;
                                end else begin
                                    state_q     <= StWdata;
                                    eng_cmd_q   <= CmdWrite;
                                    eng_wdata_q <= own_wdata;
                                end
                            end
                            StWdata: begin
                                cnt_q       <= cnt_inc;
                                eng_valid_q <= 1'b1;
                                if (bus.eng_nack || cnt_inc == len_q) begin
                                    nack_q    <= bus.eng_nack;
                                    state_q   <= StStop;
                                    eng_cmd_q <= CmdStop;
                                end else begin
                                    eng_cmd_q   <= CmdWrite;
                                    eng_wdata_q <= own_wdata;
                                end
                            end
                            StRdata: begin
                                rd_data_q   <= bus.eng_rdata;
                                rd_valid_q  <= grant_q;
                                cnt_q       <= cnt_inc;
                                eng_valid_q <= 1'b1;
                                if (cnt_inc == len_q) begin
                                    state_q   <= StStop;
                                    eng_cmd_q <= CmdStop;
                                end else begin
                                    eng_cmd_q <= (cnt_inc == len_q - 6'd1) ? CmdReadNack
                                                                            : CmdReadAck;
                                end
                            end
                            StStop: begin
                                state_q <= StDone;
                                done_q  <= grant_q;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomised scoreboard bench for i2c_txn_arbiter with a requester model, an engine model
// and a transaction-level reference that predicts commands, read bytes and completions.
module tb_i2c_txn_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NREQ(N)) bus ();
    i2c_txn_arbiter #(.NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [2:0] cmd; logic [7:0] wdata; int owner; bit pop; } exp_cmd_t;
    typedef struct { bit nack; logic [7:0] rdata; } resp_t;
    typedef struct { int owner; logic [7:0] data; } exp_rd_t;
    typedef struct { int owner; bit nack; } exp_done_t;

    exp_cmd_t  cmd_q[$];
    resp_t     resp_q[$];
    exp_rd_t   rd_q[$];
    exp_done_t done_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int model_last = N - 1;
    bit mon_en = 1'b0;
    bit flush = 1'b0;
    bit fast = 1'b1;

    // Per-requester transaction descriptors (written by the main sequence).
    logic [6:0] d_addr[N];
    bit         d_rw[N];
    int         d_len[N];
    int         d_nack_at[N];   // -1 none, 0 address, k>0 data byte k-1
    logic [7:0] d_wdat[N][32];
    logic [7:0] d_rdat[N][32];
    int launch_cnt[N];
    int finish_cnt[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic push_cmd(input logic [2:0] c, input logic [7:0] wd, input int owner,
                            input bit pop, input bit nk, input logic [7:0] rd);
        cmd_q.push_back('{c, wd, owner, pop});
        resp_q.push_back('{nk, rd});
    endtask

    // Expected command stream of one whole transaction, from its descriptor.
    task automatic push_txn(input int i);
        int L;
        bit nk;
        L = (d_len[i] > 32) ? 32 : d_len[i];
        nk = 1'b0;
        push_cmd(3'd1, 8'h00, i, 1'b0, 1'($urandom), 8'($urandom));
        push_cmd(3'd2, {d_addr[i], d_rw[i]}, i, 1'b0, d_nack_at[i] == 0, 8'h00);
        if (d_nack_at[i] == 0) begin
            nk = 1'b1;
        end else if (d_rw[i]) begin
            for (int k = 0; k < L; k++) begin
                push_cmd((k == L - 1) ? 3'd4 : 3'd3, 8'h00, i, 1'b0, 1'($urandom),
                         d_rdat[i][k]);
                rd_q.push_back('{i, d_rdat[i][k]});
            end
        end else begin
            for (int k = 0; k < L && !nk; k++) begin
                push_cmd(3'd2, d_wdat[i][k], i, 1'b1, d_nack_at[i] == k + 1, 8'h00);
                if (d_nack_at[i] == k + 1) nk = 1'b1;
            end
        end
        push_cmd(3'd5, 8'h00, i, 1'b0, 1'($urandom), 8'($urandom));
        done_q.push_back('{i, nk});
    endtask

    task automatic rand_desc(input int i);
        d_addr[i] = 7'($urandom);
        d_rw[i] = 1'($urandom);
        d_len[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 10);
        d_nack_at[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
        for (int k = 0; k < 32; k++) begin
            d_wdat[i][k] = 8'($urandom);
            d_rdat[i][k] = 8'($urandom);
        end
    endtask

    // Launch all requesters in mask together; service order is round-robin from last+1.
    task automatic run_round(input logic [N-1:0] mask);
        int order[$];
        bit all_done;
        int cyc;
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (model_last + off) % N;
            if (mask[c]) order.push_back(c);
        end
        foreach (order[k]) push_txn(order[k]);
        if (order.size() > 0) model_last = order[order.size() - 1];
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) if (mask[i]) launch_cnt[i]++;
        all_done = 1'b0;
        for (cyc = 0; cyc < 4000 && !all_done; cyc++) begin
            @(negedge clk);
            #3;
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (launch_cnt[i] != finish_cnt[i]) all_done = 1'b0;
        end
        if (!all_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL round_timeout: requests pending after %0d cycles, expected done", cyc);
            finish_test();
        end
        check("cmd_q_drained", 32'(cmd_q.size()), 0);
        check("rd_q_drained", 32'(rd_q.size()), 0);
        check("done_q_drained", 32'(done_q.size()), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_wr_pop"}, 32'(bus.wr_pop), 0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_nack"}, 32'(bus.nack), 0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        check({tag, "_eng_valid"}, 32'(bus.eng_valid), 0);
        check({tag, "_eng_wdata"}, 32'(bus.eng_wdata), 0);
        check({tag, "_eng_cmd"}, 32'(bus.eng_cmd), 0);
    endtask

    // Requester model: holds req until done, advances the write byte the cycle after wr_pop.
    initial begin
        int widx[N];
        int seen_l[N];
        bit adv[N];
        bit fin[N];
        for (int i = 0; i < N; i++) begin
            widx[i] = 0;
            seen_l[i] = 0;
            adv[i] = 1'b0;
            fin[i] = 1'b0;
            finish_cnt[i] = 0;
        end
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_rw = '0;
        bus.req_len = '0;
        bus.wr_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (flush) begin
                    finish_cnt[i] = launch_cnt[i];
                    adv[i] = 1'b0;
                    fin[i] = 1'b0;
                end
                if (seen_l[i] != launch_cnt[i]) begin
                    seen_l[i] = launch_cnt[i];
                    widx[i] = 0;
                end
                if (adv[i]) begin
                    widx[i]++;
                    adv[i] = 1'b0;
                end
                if (fin[i]) begin
                    finish_cnt[i]++;
                    fin[i] = 1'b0;
                end
                bus.req[i] = (launch_cnt[i] != finish_cnt[i]);
                bus.req_addr[7*i +: 7] = d_addr[i];
                bus.req_rw[i] = d_rw[i];
                bus.req_len[6*i +: 6] = 6'(d_len[i]);
                bus.wr_data[8*i +: 8] = d_wdat[i][(widx[i] < 32) ? widx[i] : 31];
            end
            #2;
            for (int i = 0; i < N; i++) begin
                if (bus.wr_pop[i]) adv[i] = 1'b1;
                if (bus.done[i]) fin[i] = 1'b1;
            end
        end
    end

    // Engine model: random ready with 5-cycle stalls, 1..3 cycle done, stray eng_done pulses.
    initial begin
        int cd;
        int stall;
        resp_t r;
        cd = 0;
        stall = 0;
        r = '{1'b0, 8'h00};
        bus.eng_ready = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        bus.eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            bus.eng_nack = 1'($urandom);
            bus.eng_rdata = 8'($urandom);
            if (flush) begin
                cd = 0;
                stall = 0;
                bus.eng_ready = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.eng_done = 1'b1;
                        bus.eng_nack = r.nack;
                        bus.eng_rdata = r.rdata;
                    end
                end else if (!fast && bus.eng_valid && $urandom_range(0, 7) == 0) begin
                    bus.eng_done = 1'b1;
                end
                if (fast) begin
                    bus.eng_ready = 1'b1;
                end else if (stall > 0) begin
                    bus.eng_ready = 1'b0;
                    stall--;
                end else if (bus.eng_valid && $urandom_range(0, 5) == 0) begin
                    bus.eng_ready = 1'b0;
                    stall = 4;
                end else begin
                    bus.eng_ready = ($urandom_range(0, 3) != 0);
                end
                if (bus.eng_valid && bus.eng_ready) begin
                    r = (resp_q.size() > 0) ? resp_q.pop_front() : '{1'b0, 8'h00};
                    cd = fast ? 1 : $urandom_range(1, 3);
                end
            end
        end
    end

    // Monitor: compares every accepted command, read byte and completion with the scoreboard.
    initial begin
        exp_cmd_t  e;
        exp_rd_t   er;
        exp_done_t ed;
        bit         p_stall;
        logic [2:0] p_cmd;
        logic [7:0] p_wd;
        p_stall = 1'b0;
        p_cmd = '0;
        p_wd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                logic [N-1:0] exp_pop;
                exp_pop = '0;
                if (bus.eng_valid && bus.eng_ready) begin
                    if (cmd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_cmd: got cmd %0d, expected none", bus.eng_cmd);
                    end else begin
                        e = cmd_q.pop_front();
                        check("eng_cmd", 32'(bus.eng_cmd), 32'(e.cmd));
                        if (e.cmd == 3'd2) check("eng_wdata", 32'(bus.eng_wdata), 32'(e.wdata));
                        check("grant", 32'(bus.grant), 32'(1) << e.owner);
                        if (e.pop) exp_pop = N'(1) << e.owner;
                    end
                    check("wr_pop", 32'(bus.wr_pop), 32'(exp_pop));
                end else if (bus.wr_pop != '0) begin
                    check("wr_pop_no_accept", 32'(bus.wr_pop), 0);
                end
                if (p_stall) begin
                    check("stall_valid", 32'(bus.eng_valid), 1);
                    check("stall_cmd", 32'(bus.eng_cmd), 32'(p_cmd));
                    check("stall_wdata", 32'(bus.eng_wdata), 32'(p_wd));
                end
                if (bus.rd_valid != '0) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rd_valid: got 0x%0h, expected 0", bus.rd_valid);
                    end else begin
                        er = rd_q.pop_front();
                        check("rd_valid", 32'(bus.rd_valid), 32'(1) << er.owner);
                        check("rd_data", 32'(bus.rd_data), 32'(er.data));
                    end
                end
                if (bus.done != '0) begin
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got 0x%0h, expected 0", bus.done);
                    end else begin
                        ed = done_q.pop_front();
                        check("done", 32'(bus.done), 32'(1) << ed.owner);
                        check("done_nack", 32'(bus.nack), 32'(ed.nack));
                    end
                end
            end
            p_stall = mon_en && bus.eng_valid && !bus.eng_ready;
            p_cmd = bus.eng_cmd;
            p_wd = bus.eng_wdata;
        end
    end

    // Global time limit so a wedged design still reaches the summary line.
    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        finish_test();
    end

    initial begin
        bit found;
        for (int i = 0; i < N; i++) begin
            launch_cnt[i] = 0;
            rand_desc(i);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_idle_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Two-byte write from requester 0, always-ready engine.
        d_addr[0] = 7'h55; d_rw[0] = 1'b0; d_len[0] = 2; d_nack_at[0] = -1;
        d_wdat[0][0] = 8'hA1; d_wdat[0][1] = 8'hB2;
        run_round(3'b001);

        // Three-byte read from requester 1.
        d_addr[1] = 7'h3C; d_rw[1] = 1'b1; d_len[1] = 3; d_nack_at[1] = -1;
        d_rdat[1][0] = 8'h11; d_rdat[1][1] = 8'h22; d_rdat[1][2] = 8'h33;
        run_round(3'b010);

        fast = 1'b0;

        // Address NACK on a four-byte write.
        d_addr[0] = 7'h12; d_rw[0] = 1'b0; d_len[0] = 4; d_nack_at[0] = 0;
        run_round(3'b001);

        // Requesters 0 and 1 competing with zero-length transactions.
        for (int r = 0; r < 4; r++) begin
            rand_desc(0);
            rand_desc(1);
            d_len[0] = 0;
            d_len[1] = 0;
            d_nack_at[0] = -1;
            d_nack_at[1] = -1;
            run_round(3'b011);
        end

        // NACK on the third data byte, then an over-long length that clamps to 32.
        rand_desc(2);
        d_rw[2] = 1'b0; d_len[2] = 5; d_nack_at[2] = 3;
        run_round(3'b100);
        rand_desc(0);
        d_rw[0] = 1'b0; d_len[0] = 45; d_nack_at[0] = -1;
        run_round(3'b001);

        // Random mixes of all requesters.
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) rand_desc(i);
            run_round(mask);
        end

        // Reset in the middle of a read, then a clean read from requester 1.
        rand_desc(1);
        d_rw[1] = 1'b1; d_len[1] = 10; d_nack_at[1] = -1;
        push_txn(1);
        @(negedge clk);
        #1;
        launch_cnt[1]++;
        found = 1'b0;
        for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
            @(negedge clk);
            #3;
            if (bus.eng_valid && bus.eng_cmd == 3'd3) found = 1'b1;
        end
        check("reached_rdata", 32'(found), 1);
        rst = 1'b1;
        mon_en = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        #3;
        check_idle_outputs("mid_reset");
        cmd_q.delete();
        resp_q.delete();
        rd_q.delete();
        done_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        mon_en = 1'b1;
        model_last = N - 1;
        rand_desc(1);
        d_rw[1] = 1'b1; d_len[1] = 4; d_nack_at[1] = -1;
        run_round(3'b010);

        repeat (3) @(negedge clk);
        finish_test();
    end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

- Shares one byte-level I2C master engine between `NREQ` requesters, for example a sensor poller and a display writer.
- Arbitrates round-robin and sequences each granted request as a full I2C transaction: START, address byte, 0..32 data bytes, STOP.
- Reports per-byte data, completion and NACK status back to the owning requester.
- Sits between the application blocks and the I2C bus engine that drives SDA/SCL; the engine's internals are out of scope.

## Interface
- `NREQ`, default 2 — number of requesters, legal values 2..4.
- `clk` in 1 — clock, all logic on the rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `req` in NREQ — request per requester; hold high until its `done` pulse.
- `req_addr` in 7*NREQ — 7-bit target address per requester, slot i at bits [7i+6:7i].
- `req_rw` in NREQ — 1 = read, 0 = write.
- `req_len` in 6*NREQ — byte count 0..32; values above 32 are clamped to 32.
- `wr_data` in 8*NREQ — next write byte per requester.
- `grant` out NREQ — one-hot owner of the current transaction.
- `wr_pop` out NREQ — one-cycle pulse when the owner's `wr_data` byte is consumed; the requester presents the next byte the following cycle.
- `rd_data` out 8 — last byte read.
- `rd_valid` out NREQ — one-cycle pulse to the owner when `rd_data` is valid.
- `done` out NREQ — one-cycle pulse to the owner at transaction end.
- `nack` out 1 — valid with `done`; 1 means the address or a write byte was NACKed.
- `eng_cmd` out 3 — command to the engine: 0 NONE, 1 START, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP.
- `eng_wdata` out 8 — byte sent with a WRITE command.
- `eng_valid` out 1 — command valid.
- `eng_ready` in 1 — engine accepts the command.
- `eng_done` in 1 — one-cycle pulse when the accepted command finishes.
- `eng_rdata` in 8 — read byte, valid with `eng_done` of a READ command.
- `eng_nack` in 1 — valid with `eng_done` of a WRITE command.

## Operation
- **States:** IDLE, START, ADDR, WDATA, RDATA, STOP, DONE.
- **IDLE:**
  - If any `req` is high, pick the winner by round-robin starting at `last+1` (mod NREQ).
  - Register `grant`, latch the winner's addr, rw and clamped len, clear the byte counter, go to START.
  - `last` resets to NREQ-1, so requester 0 has first priority after reset.
- **Command handshake:**
  - Each non-IDLE/DONE state issues exactly one command.
  - `eng_valid` is held with a stable `eng_cmd`/`eng_wdata` until a cycle where `eng_valid && eng_ready`.
  - `eng_valid` then drops and the FSM waits for `eng_done`.
  - Only one command is outstanding at a time.
- **START:** on `eng_done`, go to ADDR.
- **ADDR:**
  - WRITE of `{addr, rw}`.
  - On `eng_done`: if `eng_nack`, set the nack flag and go to STOP.
  - Otherwise, if len==0 go to STOP, else go to WDATA (rw=0) or RDATA (rw=1).
- **WDATA:**
  - `eng_wdata` = owner's `wr_data`; `wr_pop` pulses in the accept cycle.
  - On `eng_done`: increment the count; if `eng_nack`, set the nack flag and go to STOP.
  - Otherwise, if count==len go to STOP, else repeat WDATA.
- **RDATA:**
  - Command is READ_ACK, or READ_NACK for the last byte (count==len-1).
  - On `eng_done`: `rd_data` <= `eng_rdata`, `rd_valid` to the owner, increment the count.
  - If count==len go to STOP, else repeat RDATA.
  - A read never sets nack.
- **STOP:** on `eng_done`, go to DONE.
- **DONE:** pulse `done[owner]` with `nack`, set `last` = owner, clear `grant`, go to IDLE.
- **Requester behaviour:**
  - A requester dropping `req` mid-transaction is ignored; the transaction runs to completion.
  - `req_*` inputs are sampled only in IDLE.

## Timing
- **Reset values:**
  - `grant`, `wr_pop`, `rd_valid`, `done`: 0.
  - `nack`, `rd_data`, `eng_valid`, `eng_wdata`: 0.
  - `eng_cmd`: NONE.
- **Reset mid-transaction:**
  - All outputs take their reset values at the next edge, including `eng_valid` dropping with no STOP issued.
  - Recovery of the bus is left to the engine's own reset.
- **Start latency:** `req` high in IDLE at edge k gives `grant` and `eng_valid`=1 with START from edge k+1.
- **Acceptance:** a command accepted at edge n has `eng_valid`=0 from edge n+1. The next command is asserted the cycle after the `eng_done` that ends the previous one.
- **Same-cycle `eng_ready` and `eng_done`:** an `eng_done` in the same cycle as acceptance is ignored. Completion is only recognised after acceptance.
- **Back-to-back transactions:** `done` is in cycle d, `grant`=0 in cycle d+1 (IDLE), and the earliest next `grant` is at d+2.
- **Simultaneous requests:** resolved purely by round-robin. With all requesters always requesting, each gets every NREQ-th transaction.

## Test plan
- **Write, 2 bytes:**
  - Stimulus: req0 addr 0x55, rw=0, len=2, data 0xA1 then 0xB2; engine always ready with 1-cycle done.
  - Response: commands START, WRITE 0xAA, WRITE 0xA1, WRITE 0xB2, STOP.
  - Response: 2 `wr_pop` pulses, `done[0]` with nack=0.
- **Read, 3 bytes:**
  - Stimulus: req1 addr 0x3C, rw=1, len=3; engine returns 0x11, 0x22, 0x33.
  - Response: WRITE 0x79, READ_ACK, READ_ACK, READ_NACK, STOP.
  - Response: `rd_valid[1]` ×3 with matching `rd_data`, then `done[1]`.
- **Address NACK:**
  - Stimulus: `eng_nack`=1 on the address byte of a len=4 write.
  - Response: STOP immediately after the address, 0 `wr_pop`, `done` with nack=1.
- **Round-robin fairness:**
  - Stimulus: req0 and req1 held high continuously after reset.
  - Response: grants alternate 0,1,0,1.
  - Response: len=0 requests issue only START, ADDR, STOP.
- **Handshake stall:** `eng_ready` low for 5 cycles on the WRITE of a data byte -> `eng_cmd` and `eng_wdata` stable throughout, exactly one `wr_pop`.
- **Reset mid-read:** `rst` during RDATA -> all outputs 0 next cycle; the subsequent req1 is served cleanly.
